// File: rtl/arbitro_rr_pop.sv
// Round-robin pop arbiter: drains four upstream 6-bit FIFOs into one downstream FIFO,
// one word per pop/wait/push service, with downstream pause and per-source timeout.
module arbitro_rr_pop #(
  parameter int N_SRC   = 4,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [N_SRC-1:0] fifo_empty,
  input  logic [N_SRC-1:0] valid_in,
  input  logic [5:0]       data_in0,
  input  logic [5:0]       data_in1,
  input  logic [5:0]       data_in2,
  input  logic [5:0]       data_in3,
  input  logic             pausa,
  output logic [N_SRC-1:0] pop,
  output logic             push_out,
  output logic [5:0]       data_out,
  output logic [1:0]       grant,
  output logic             timeout_err,
  output logic             err_sticky,
  output logic [1:0]       o_dbg_state,
  output logic [1:0]       o_dbg_ptr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_WAIT = 2'd2,
    S_PUSH = 2'd3
  } state_t;

  // Handshake: pop[i] is a one-cycle request; the FIFO answers with valid_in[i] one
  // cycle later; push_out is a one-cycle strobe qualifying data_out (no ready back).

  logic             r_rst_meta;
  logic             r_rst_sync;
  logic             w_rst_n;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_grant;
  logic [3:0]       r_wait_cnt;
  logic [N_SRC-1:0] r_pop;
  logic             r_push;
  logic [5:0]       r_data;
  logic             r_timeout_err;
  logic             r_err_sticky;

  logic [7:0]       w_dbl_empty;
  logic [3:0]       w_rot_empty;
  logic [1:0]       w_off;
  logic [1:0]       w_sel;
  logic             w_any;
  logic             w_valid_g;
  logic [5:0]       w_data_g;

  // Reset asserts asynchronously and releases two clock edges later.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  // Rotate the empty flags so bit 0 is the source at r_ptr, then pick the first non-empty.
  assign w_dbl_empty = {fifo_empty, fifo_empty};
  assign w_rot_empty = w_dbl_empty[r_ptr +: 4];
  assign w_any       = ~&fifo_empty;

  always_comb begin
    w_off = 2'd3;
    if (!w_rot_empty[0])      w_off = 2'd0;
    else if (!w_rot_empty[1]) w_off = 2'd1;
    else if (!w_rot_empty[2]) w_off = 2'd2;
  end

  assign w_sel     = r_ptr + w_off;
  assign w_valid_g = valid_in[r_grant];

  always_comb begin
    w_data_g = data_in0;
    case (r_grant)
      2'd0: w_data_g = data_in0;
      2'd1: w_data_g = data_in1;
      2'd2: w_data_g = data_in2;
      2'd3: w_data_g = data_in3;
      default: w_data_g = data_in0;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= 2'd0;
      r_grant       <= 2'd0;
      r_wait_cnt    <= 4'd0;
      r_pop         <= '0;
      r_push        <= 1'b0;
      r_data        <= 6'd0;
      r_timeout_err <= 1'b0;
      r_err_sticky  <= 1'b0;
    end else begin
      r_pop         <= '0;
      r_push        <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!pausa && w_any) begin
            r_grant      <= w_sel;
            r_pop[w_sel] <= 1'b1;
            r_state      <= S_POP;
          end
        end
        S_POP: begin
          r_wait_cnt <= 4'd0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // Data arriving on the last allowed cycle still wins over the timeout.
          if (w_valid_g) begin
            r_data  <= w_data_g;
            r_push  <= 1'b1;
            r_state <= S_PUSH;
          end else if (r_wait_cnt == 4'(TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_err_sticky  <= 1'b1;
            r_ptr         <= r_grant + 2'd1;
            r_state       <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        S_PUSH: begin
          r_ptr   <= r_grant + 2'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pop         = r_pop;
  assign push_out    = r_push;
  assign data_out    = r_data;
  assign grant       = r_grant;
  assign timeout_err = r_timeout_err;
  assign err_sticky  = r_err_sticky;
  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_arbitro_rr_pop.sv
// Bench for arbitro_rr_pop: a vector table of services plus directed sequences for
// pause, timeout, data-on-timeout-edge and reset in the middle of a service.
module tb_arbitro_rr_pop;

  localparam int T = 4;

  logic       clk;
  logic       reset_L;
  logic [3:0] fifo_empty;
  logic [3:0] valid_in;
  logic [5:0] data_in0, data_in1, data_in2, data_in3;
  logic       pausa;
  logic [3:0] pop;
  logic       push_out;
  logic [5:0] data_out;
  logic [1:0] grant;
  logic       timeout_err;
  logic       err_sticky;
  logic [1:0] dbg_state;
  logic [1:0] dbg_ptr;

  arbitro_rr_pop #(.N_SRC(4), .TIMEOUT(T)) dut (
    .clk(clk), .reset_L(reset_L), .fifo_empty(fifo_empty), .valid_in(valid_in),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .pausa(pausa), .pop(pop), .push_out(push_out), .data_out(data_out), .grant(grant),
    .timeout_err(timeout_err), .err_sticky(err_sticky),
    .o_dbg_state(dbg_state), .o_dbg_ptr(dbg_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [3:0] resp_en;
  logic [3:0] noise;
  logic [3:0] prev_pop;

  typedef struct {
    logic [3:0] fe;
    logic [3:0] exp_pop;
    logic [1:0] exp_grant;
    logic [5:0] exp_data;
    logic [1:0] exp_ptr;
    bit         gap;
  } vec_t;

  vec_t vec[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Upstream FIFO model: valid_in follows the pop seen one cycle earlier.
  task automatic tick();
    @(negedge clk);
    cyc++;
    valid_in = (prev_pop & resp_en) | noise;
    prev_pop = pop;
  endtask

  task automatic wait_pop();
    int n;
    n = 0;
    tick();
    while (pop == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    if (pop == 4'b0000) chk("pop_wait_expired", 32'(pop), 32'hF);
  endtask

  task automatic apply_reset();
    fifo_empty = 4'b1111;
    pausa      = 1'b0;
    resp_en    = 4'b1111;
    noise      = 4'b0000;
    reset_L    = 1'b0;
    prev_pop   = 4'b0000;
    tick(); tick();
    reset_L = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int npop;
    int nbad;
    int last_pop;

    vec[0] = '{4'b0000, 4'b0001, 2'd0, 6'h01, 2'd1, 1'b0};
    vec[1] = '{4'b0000, 4'b0010, 2'd1, 6'h02, 2'd2, 1'b1};
    vec[2] = '{4'b0000, 4'b0100, 2'd2, 6'h03, 2'd3, 1'b1};
    vec[3] = '{4'b0000, 4'b1000, 2'd3, 6'h04, 2'd0, 1'b1};
    vec[4] = '{4'b0000, 4'b0001, 2'd0, 6'h01, 2'd1, 1'b1};
    vec[5] = '{4'b1010, 4'b0100, 2'd2, 6'h03, 2'd3, 1'b1};
    vec[6] = '{4'b1010, 4'b0001, 2'd0, 6'h01, 2'd1, 1'b1};
    vec[7] = '{4'b0111, 4'b1000, 2'd3, 6'h04, 2'd0, 1'b1};
    vec[8] = '{4'b1011, 4'b0100, 2'd2, 6'h03, 2'd3, 1'b1};
    vec[9] = '{4'b1110, 4'b0001, 2'd0, 6'h01, 2'd1, 1'b1};

    reset_L = 1'b0; fifo_empty = 4'b1111; valid_in = 4'b0000; pausa = 1'b0;
    resp_en = 4'b1111; noise = 4'b0000; prev_pop = 4'b0000;
    data_in0 = 6'h2A; data_in1 = 6'h02; data_in2 = 6'h03; data_in3 = 6'h04;
    tick(); tick();

    chk("rst_pop", 32'(pop), 32'h0);
    chk("rst_push", 32'(push_out), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_tmo", 32'(timeout_err), 32'h0);
    chk("rst_sticky", 32'(err_sticky), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    chk("rst_ptr", 32'(dbg_ptr), 32'h0);

    // Single source
    reset_L = 1'b1;
    tick(); tick(); tick();
    fifo_empty = 4'b1110;
    wait_pop();
    chk("single_pop", 32'(pop), 32'h1);
    chk("single_grant", 32'(grant), 32'h0);
    fifo_empty = 4'b1111;
    tick();
    chk("single_pop_once", 32'(pop), 32'h0);
    chk("single_push_early", 32'(push_out), 32'h0);
    tick();
    chk("single_push", 32'(push_out), 32'h1);
    chk("single_data", 32'(data_out), 32'h2A);
    tick();
    chk("single_push_end", 32'(push_out), 32'h0);
    chk("single_data_hold", 32'(data_out), 32'h2A);
    chk("single_ptr", 32'(dbg_ptr), 32'h1);
    chk("single_grant_hold", 32'(grant), 32'h0);

    // Vector table: round robin then sparse masks with wrap-around
    data_in0 = 6'h01;
    apply_reset();
    last_pop = 0;
    for (int i = 0; i < 10; i++) begin
      fifo_empty = vec[i].fe;
      wait_pop();
      if (vec[i].gap) chk("tbl_gap", 32'(cyc - last_pop), 32'd4);
      last_pop = cyc;
      chk("tbl_pop", 32'(pop), 32'(vec[i].exp_pop));
      chk("tbl_grant", 32'(grant), 32'(vec[i].exp_grant));
      tick();
      chk("tbl_pop_off", 32'(pop), 32'h0);
      tick();
      chk("tbl_push", 32'(push_out), 32'h1);
      chk("tbl_data", 32'(data_out), 32'(vec[i].exp_data));
      tick();
      chk("tbl_push_off", 32'(push_out), 32'h0);
      chk("tbl_ptr", 32'(dbg_ptr), 32'(vec[i].exp_ptr));
    end
    fifo_empty = 4'b1111;

    // Pause
    apply_reset();
    pausa = 1'b1;
    fifo_empty = 4'b0000;
    npop = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pop != 4'b0000) npop++;
    end
    chk("pause_no_pop", 32'(npop), 32'd0);
    pausa = 1'b0;
    tick();
    chk("pause_release_pop", 32'(pop), 32'h1);
    tick();
    pausa = 1'b1;
    tick();
    chk("pause_wait_push", 32'(push_out), 32'h1);
    chk("pause_wait_data", 32'(data_out), 32'h01);
    npop = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (pop != 4'b0000) npop++;
    end
    chk("pause_hold_no_pop", 32'(npop), 32'd0);
    pausa = 1'b0;
    fifo_empty = 4'b1111;
    tick(); tick(); tick(); tick(); tick();

    // Timeout on source 1, other valid_in bits toggled as noise
    apply_reset();
    resp_en = 4'b0000;
    noise = 4'b1101;
    fifo_empty = 4'b1101;
    wait_pop();
    chk("tmo_pop", 32'(pop), 32'h2);
    fifo_empty = 4'b1111;
    nbad = 0;
    for (int k = 0; k < T; k++) begin
      tick();
      if (timeout_err || push_out) nbad++;
    end
    chk("tmo_early", 32'(nbad), 32'd0);
    tick();
    chk("tmo_pulse", 32'(timeout_err), 32'h1);
    chk("tmo_sticky", 32'(err_sticky), 32'h1);
    chk("tmo_no_push", 32'(push_out), 32'h0);
    chk("tmo_ptr", 32'(dbg_ptr), 32'h2);
    chk("tmo_grant_hold", 32'(grant), 32'h1);
    noise = 4'b0000;
    tick();
    chk("tmo_pulse_end", 32'(timeout_err), 32'h0);
    chk("tmo_sticky_hold", 32'(err_sticky), 32'h1);

    resp_en = 4'b1111;
    fifo_empty = 4'b0111;
    wait_pop();
    chk("after_tmo_pop", 32'(pop), 32'h8);
    fifo_empty = 4'b1111;
    tick(); tick();
    chk("after_tmo_push", 32'(push_out), 32'h1);
    chk("after_tmo_data", 32'(data_out), 32'h04);
    chk("after_tmo_sticky", 32'(err_sticky), 32'h1);
    tick();

    // Data arriving on the same cycle the counter expires
    resp_en = 4'b0000;
    fifo_empty = 4'b1110;
    wait_pop();
    chk("edge_pop", 32'(pop), 32'h1);
    fifo_empty = 4'b1111;
    for (int k = 0; k < T - 1; k++) tick();
    tick();
    valid_in = 4'b0001;
    tick();
    chk("edge_push", 32'(push_out), 32'h1);
    chk("edge_data", 32'(data_out), 32'h01);
    chk("edge_no_tmo", 32'(timeout_err), 32'h0);
    tick();

    // Reset while in WAIT with valid_in present on the next edge
    resp_en = 4'b1111;
    fifo_empty = 4'b0000;
    wait_pop();
    chk("midrst_pop", 32'(pop), 32'h2);
    tick();
    #3;
    reset_L = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_sticky", 32'(err_sticky), 32'h0);
    chk("midrst_data", 32'(data_out), 32'h0);
    chk("midrst_state", 32'(dbg_state), 32'h0);
    tick(); tick();
    prev_pop = 4'b0000;
    reset_L = 1'b1;
    nbad = 0;
    npop = 0;
    while (pop == 4'b0000 && npop < 20) begin
      tick();
      if (push_out) nbad++;
      npop++;
    end
    chk("midrst_no_push", 32'(nbad), 32'd0);
    chk("midrst_first_pop", 32'(pop), 32'h1);
    fifo_empty = 4'b1111;
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
